// File: rtl/multicycle_datapath.sv
// RV32I-subset multicycle datapath: PC/OldPC/IR/MDR/A/B/ALUOut, register file,
// immediate extender and ALU, steered by the multicycle controller's selects.
module multicycle_datapath #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ImmSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic            AdrSrc,
    input  logic [2:0]      ALUControl,
    input  logic            IRWrite,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] ReadData,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            Zero
);

    logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [XLEN-1:0] imm_ext, src_a, src_b, alu_result, result, diff;
    logic            overflow, sign_bit;
    logic [4:0]      rs1, rs2, rd;

    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rd       = ir_q[11:7];
    assign sign_bit = ir_q[31];

    always_comb begin
        imm_ext = '0;
        case (ImmSrc)
            2'b00: imm_ext = {{(XLEN-12){sign_bit}}, ir_q[31:20]};
            2'b01: imm_ext = {{(XLEN-12){sign_bit}}, ir_q[31:25], ir_q[11:7]};
            2'b10: imm_ext = {{(XLEN-13){sign_bit}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            2'b11: imm_ext = {{(XLEN-21){sign_bit}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        src_a = '0;
        case (ALUSrcA)
            2'b00: src_a = pc_q;
            2'b01: src_a = old_pc_q;
            2'b10: src_a = a_q;
            default: src_a = '0;
        endcase
        src_b = '0;
        case (ALUSrcB)
            2'b00: src_b = b_q;
            2'b01: src_b = imm_ext;
            2'b10: src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    // Signed less-than uses the difference sign corrected by overflow.
    always_comb begin
        diff       = src_a - src_b;
        overflow   = (src_a[XLEN-1] ^ src_b[XLEN-1]) & (diff[XLEN-1] ^ src_a[XLEN-1]);
        alu_result = '0;
        case (ALUControl)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = diff;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b101: alu_result = {{(XLEN-1){1'b0}}, diff[XLEN-1] ^ overflow};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (ResultSrc)
            2'b00: result = alu_out_q;
            2'b01: result = mdr_q;
            2'b10: result = alu_result;
            default: result = '0;
        endcase
    end

    always_comb begin
        pc_d      = PCWrite ? result : pc_q;
        old_pc_d  = IRWrite ? pc_q : old_pc_q;
        ir_d      = IRWrite ? ReadData[31:0] : ir_q;
        mdr_d     = ReadData;
        a_d       = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        b_d       = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        alu_out_d = alu_result;
    end

    // x0 is never written, so its storage stays at the reset value of zero.
    always_comb begin
        rf_d = rf_q;
        if (RegWrite && (rd != 5'd0)) begin
            rf_d[rd] = result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= '0;
            ir_q      <= NOP_INSTR;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            rf_q      <= rf_d;
        end
    end

    assign Adr       = AdrSrc ? result : pc_q;
    assign WriteData = b_q;
    assign op        = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7b5  = ir_q[30];
    assign Zero      = (alu_result == '0);

endmodule
